pmem_burst_responder: RTL

- Memory-side responder for the cache physical-memory interface.
- Accepts 256-bit line read/write requests from a cache (pmem_read/pmem_write/pmem_resp handshake) and performs them on the DRAM model as 4-beat, 64-bit bursts.
- Sits between the dcache/icache (or arbiter) and physical memory.
- Assembles read beats into a line and splits write lines into beats.

---
 rtl/pmem_burst_pkg.sv | 21 ++
 rtl/pmem_burst_responder.sv | 100 ++++++++++
 2 files changed

// File: rtl/pmem_burst_pkg.sv
// Shared types and constants for the cache-line to 4-beat DRAM burst responder.
package pmem_burst_pkg;

  localparam int BEAT_W   = 64;
  localparam int BEATS    = 4;
  localparam int LINE_W   = BEAT_W * BEATS;
  localparam int OFFSET_W = 5;

  typedef logic [$clog2(BEATS)-1:0] beat_idx_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    RESP,
    DONE
  } state_t;

endpackage

// File: rtl/pmem_burst_responder.sv
// Serves 256-bit cache line reads/writes as 4-beat, 64-bit bursts on the memory side.
// Handshake: cache holds pmem_read/pmem_write until the one-cycle pmem_resp; each memory beat completes on burst_resp=1.
module pmem_burst_responder
  import pmem_burst_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pmem_address,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic [31:0]       burst_addr,
  output logic              burst_read,
  output logic              burst_write,
  output logic [BEAT_W-1:0] burst_wdata,
  input  logic [BEAT_W-1:0] burst_rdata,
  input  logic              burst_resp
);

  state_t                         state_q, state_d;
  beat_idx_t                      cnt_q, cnt_d;
  logic [BEATS-1:0][BEAT_W-1:0]   rline_q;
  logic [BEATS-1:0][BEAT_W-1:0]   wline_q;
  logic [31:0]                    addr_q;
  logic                           accept_rd, accept_wr;
  logic                           unused_offset;

  // Offset bits select a byte within the line and never reach the memory side.
  assign unused_offset = &{1'b0, pmem_address[OFFSET_W-1:0]};

  assign accept_rd = (state_q == IDLE) && pmem_read;
  assign accept_wr = (state_q == IDLE) && !pmem_read && pmem_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rline_q <= '0;
      wline_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_rd || accept_wr) begin
        addr_q <= {pmem_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
      end
      if (accept_wr) begin
        wline_q <= pmem_wdata;
      end
      if ((state_q == READ) && burst_resp) begin
        rline_q[cnt_q] <= burst_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pmem_read) begin
          state_d = READ;
        end else if (pmem_write) begin
          state_d = WRITE;
        end
      end
      READ, WRITE: begin
        if (burst_resp) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = RESP;
            cnt_d   = '0;
          end else begin
            cnt_d = beat_idx_t'(cnt_q + 1'b1);
          end
        end
      end
      RESP:    state_d = DONE;
      // The cache drops its request the cycle after pmem_resp; ignore it here.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pmem_rdata  = rline_q;
  assign pmem_resp   = (state_q == RESP);
  assign burst_addr  = addr_q;
  assign burst_read  = (state_q == READ);
  assign burst_write = (state_q == WRITE);
  assign burst_wdata = (state_q == WRITE) ? wline_q[cnt_q] : '0;

  always @(posedge clk) begin
    if (!rst) begin
      assert (!((state_q == IDLE) && pmem_read && pmem_write))
        else $warning("pmem_read and pmem_write asserted together; read served");
    end
  end

endmodule
